fetch_seq: RTL

Sequencer in front of the fetch decoder. It owns the PC and fetches one variable-length Y86-64 instruction at a time from a byte-wide instruction memory over a req/ack handshake. It assembles the bytes into an 80-bit instruction window and presents it downstream with a valid/ready handshake. It then advances the PC by the instruction length or to a redirect target supplied by the execute/writeback side, and traps on halt, bad address or invalid icode.

---
 rtl/fetch_seq_if.sv | 25 ++
 rtl/fetch_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_if.sv
// Instruction-memory and downstream instruction handshake bundle for fetch_seq.
// master = the sequencer, slave = memory/decoder side.
interface fetch_seq_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic [79:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] pc_out;
    logic [63:0] valp_out;
    logic        next_pc_vld;
    logic [63:0] next_pc;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc_out, valp_out,
        input  imem_ack, imem_rdata, instr_ready, next_pc_vld, next_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc_out, valp_out,
        output imem_ack, imem_rdata, instr_ready, next_pc_vld, next_pc
    );
endinterface

// File: rtl/fetch_seq.sv
// Y86-64 fetch sequencer: byte-wise instruction fetch, 80-bit window, PC advance.
// Optional FETCH_PERF_EN adds handoff and memory-stall counters.
module fetch_seq #(
    parameter logic [63:0] MEM_LIMIT = 64'd1023,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] start_pc,
    fetch_seq_if.master bus,
    output logic        busy,
    output logic        halted,
    output logic        mem_err,
    output logic        instr_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_instr_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_HALT, S_ERR} state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic [3:0]  idx_reg;
    logic [3:0]  len_reg;
    logic        req_reg;
    logic [63:0] addr_reg;
    logic [63:0] pc_out_reg;
    logic [63:0] valp_reg;
    logic        halted_reg;
    logic        mem_err_reg;
    logic        instr_err_reg;
    logic [79:0] instr_w;

    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    logic [63:0] fetch_addr;
    logic [3:0]  icode_now;
    logic [3:0]  byte_len;
    logic        last_byte;
    logic        byte_wr;
    logic        handoff;
    logic        is_halt;
    logic        lane_clr;

    assign fetch_addr = pc_reg + {60'd0, idx_reg};
    assign icode_now  = bus.imem_rdata[7:4];
    // Byte 0 supplies the length in the same cycle it arrives.
    assign byte_len   = (idx_reg == 4'd0) ? len_of(icode_now) : len_reg;
    assign last_byte  = (4'(idx_reg + 4'd1) == byte_len);
    assign byte_wr    = (state_reg == S_FETCH) && req_reg && bus.imem_ack;
    assign handoff    = (state_reg == S_PRESENT) && bus.instr_ready;
    assign is_halt    = (instr_w[7:4] == 4'h0);
    assign lane_clr   = ((state_reg == S_IDLE) && start) || (handoff && !is_halt);

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (reset || lane_clr)
                    lane_reg <= '0;
                else if (byte_wr && idx_reg == 4'(gi))
                    lane_reg <= bus.imem_rdata;
            end
            assign instr_w[8*gi +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            idx_reg       <= '0;
            len_reg       <= '0;
            req_reg       <= 1'b0;
            addr_reg      <= '0;
            pc_out_reg    <= '0;
            valp_reg      <= '0;
            halted_reg    <= 1'b0;
            mem_err_reg   <= 1'b0;
            instr_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        pc_reg    <= start_pc;
                        idx_reg   <= '0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!req_reg) begin
                        // Address is checked before a request ever goes out.
                        if (fetch_addr > MEM_LIMIT) begin
                            mem_err_reg <= 1'b1;
                            state_reg   <= S_ERR;
                        end else begin
                            req_reg  <= 1'b1;
                            addr_reg <= fetch_addr;
                        end
                    end else if (bus.imem_ack) begin
                        req_reg <= 1'b0;
                        if (idx_reg == 4'd0)
                            len_reg <= len_of(icode_now);
                        if (idx_reg == 4'd0 && icode_now > 4'hB) begin
                            instr_err_reg <= 1'b1;
                            state_reg     <= S_ERR;
                        end else if (last_byte) begin
                            pc_out_reg <= pc_reg;
                            valp_reg   <= pc_reg + {60'd0, byte_len};
                            state_reg  <= S_PRESENT;
                        end else begin
                            idx_reg <= 4'(idx_reg + 4'd1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (bus.instr_ready) begin
                        if (is_halt) begin
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALT;
                        end else begin
                            pc_reg    <= bus.next_pc_vld ? bus.next_pc : valp_reg;
                            idx_reg   <= '0;
                            state_reg <= S_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_instr_reg;
    logic [31:0] perf_stall_reg;

    // Requests only exist in FETCH and handoffs only in PRESENT, so both freeze in HALT/ERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (handoff && perf_instr_reg != 32'hFFFF_FFFF)
                perf_instr_reg <= perf_instr_reg + 32'd1;
            if (req_reg && !bus.imem_ack && perf_stall_reg != 32'hFFFF_FFFF)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_instr_cnt = perf_instr_reg;
    assign perf_stall_cnt = perf_stall_reg;
`endif

    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = addr_reg;
    assign bus.instr       = instr_w;
    assign bus.instr_valid = (state_reg == S_PRESENT);
    assign bus.pc_out      = pc_out_reg;
    assign bus.valp_out    = valp_reg;
    assign busy            = (state_reg == S_FETCH) || (state_reg == S_PRESENT);
    assign halted          = halted_reg;
    assign mem_err         = mem_err_reg;
    assign instr_err       = instr_err_reg;
endmodule
